// File: rtl/xeng_corr_framer.sv
// X-engine correlator framer: subtracts shifted correction terms from accumulations and frames the result.
// Define XENG_CORR_SAT_EN to saturate each output component instead of wrapping.
module xeng_corr_framer #(
    parameter int N_STOKES       = 1,
    parameter int ACC_COMP_WIDTH = 18,
    parameter int CORR_WIDTH     = 14,
    parameter int CORR_SHIFT     = 3,
    parameter int N_BLS          = 2112,
    parameter int MCNT_WIDTH     = 48,
    localparam int IW            = (N_BLS > 1) ? $clog2(N_BLS) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   sync_in,
    input  logic                                   acc_vld,
    input  logic [N_STOKES*2*ACC_COMP_WIDTH-1:0]   acc_in,
    input  logic [N_STOKES*CORR_WIDTH-1:0]         corr_re,
    input  logic [N_STOKES*CORR_WIDTH-1:0]         corr_im,
    input  logic [MCNT_WIDTH-1:0]                  mcnt_in,
    input  logic                                   dout_rdy,
    output logic [N_STOKES*2*ACC_COMP_WIDTH-1:0]   dout,
    output logic                                   dout_vld,
    output logic                                   dout_sof,
    output logic                                   dout_eof,
    output logic [IW-1:0]                          bl_idx,
    output logic [MCNT_WIDTH-1:0]                  mcnt_out,
    output logic                                   frame_err,
    output logic [15:0]                            drop_cnt
);
    localparam int CW = ACC_COMP_WIDTH;
    localparam int DW = ACC_COMP_WIDTH + 2;
    localparam int WW = N_STOKES * 2 * ACC_COMP_WIDTH;
    localparam logic [IW-1:0] LAST = IW'(N_BLS - 1);
    localparam logic signed [DW-1:0] SMAX = $signed(DW'((64'd1 << (CW - 1)) - 64'd1));
    localparam logic signed [DW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, ARMED, FRAME} state_t;

    typedef struct packed {
        logic [WW-1:0]         data;
        logic                  sof;
        logic                  eof;
        logic [IW-1:0]         idx;
        logic [MCNT_WIDTH-1:0] mcnt;
    } word_t;

    state_t                state_reg, state_next;
    logic [IW-1:0]         cnt_reg, cnt_next;
    logic [MCNT_WIDTH-1:0] mcnt_hold_reg;
    logic                  frame_err_reg, err_next;
    logic                  take, w_sof, w_eof;
    logic [IW-1:0]         w_idx;
    logic [WW-1:0]         corr_word;
    logic                  s1_vld_reg;
    word_t                 s1_reg;
    word_t                 fifo_mem [2];
    logic                  wr_ptr_reg, rd_ptr_reg;
    logic [1:0]            count_reg;
    logic [15:0]           drop_cnt_reg;
    logic                  push, pop, drop;

    // Component gi: even = imag, odd = real of Stokes gi/2.
    generate
        for (genvar gi = 0; gi < 2 * N_STOKES; gi++) begin : g_comp
            logic [CORR_WIDTH-1:0] corr;
            logic signed [DW-1:0]  diff;
            assign corr = (gi % 2 == 1) ? corr_re[(gi/2)*CORR_WIDTH +: CORR_WIDTH]
                                        : corr_im[(gi/2)*CORR_WIDTH +: CORR_WIDTH];
            assign diff = $signed(DW'(acc_in[gi*CW +: CW]) - (DW'(corr) << CORR_SHIFT));
`ifdef XENG_CORR_SAT_EN
            assign corr_word[gi*CW +: CW] = (diff > SMAX) ? SMAX[CW-1:0] :
                                            (diff < SMIN) ? SMIN[CW-1:0] : diff[CW-1:0];
`else
            assign corr_word[gi*CW +: CW] = diff[CW-1:0];
`endif
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        take       = 1'b0;
        w_sof      = 1'b0;
        w_eof      = 1'b0;
        w_idx      = cnt_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: if (sync_in) state_next = ARMED;
            ARMED, FRAME: begin
                if (state_reg == FRAME && sync_in) begin
                    err_next   = (cnt_reg != '0);
                    state_next = ARMED;
                    cnt_next   = '0;
                end
                if (acc_vld) begin
                    take = 1'b1;
                    if (state_reg == ARMED || sync_in) begin
                        w_sof = 1'b1;
                        w_idx = '0;
                    end
                    if (w_idx == LAST) begin
                        w_eof      = 1'b1;
                        cnt_next   = '0;
                        state_next = ARMED;
                    end else begin
                        cnt_next   = w_idx + IW'(1);
                        state_next = FRAME;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            mcnt_hold_reg <= '0;
            frame_err_reg <= 1'b0;
            s1_vld_reg    <= 1'b0;
            s1_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            frame_err_reg <= err_next;
            s1_vld_reg    <= take;
            if (sync_in) mcnt_hold_reg <= mcnt_in;
            if (take) begin
                s1_reg.data <= corr_word;
                s1_reg.sof  <= w_sof;
                s1_reg.eof  <= w_eof;
                s1_reg.idx  <= w_idx;
                s1_reg.mcnt <= sync_in ? mcnt_in : mcnt_hold_reg;
            end
        end
    end

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign pop  = (count_reg != 2'd0) && dout_rdy;
    assign push = s1_vld_reg && ((count_reg != 2'd2) || dout_rdy);
    assign drop = s1_vld_reg && (count_reg == 2'd2) && !dout_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            drop_cnt_reg <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_reg] <= s1_reg;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (pop) rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
            if (drop && drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign dout      = fifo_mem[rd_ptr_reg].data;
    assign dout_vld  = (count_reg != 2'd0);
    assign dout_sof  = dout_vld && fifo_mem[rd_ptr_reg].sof;
    assign dout_eof  = dout_vld && fifo_mem[rd_ptr_reg].eof;
    assign bl_idx    = fifo_mem[rd_ptr_reg].idx;
    assign mcnt_out  = fifo_mem[rd_ptr_reg].mcnt;
    assign frame_err = frame_err_reg;
    assign drop_cnt  = drop_cnt_reg;
endmodule

// File: doc/xeng_corr_framer.md
XENG_CORR_FRAMER -- requirements
Module: xeng_corr_framer

Interface
REQ-001 Parameter N_STOKES, default 1: Stokes products per baseline word (1 or 4).
REQ-002 Parameter ACC_COMP_WIDTH, default 18: bits per real or imag accumulator component.
REQ-003 Parameter CORR_WIDTH, default 14: bits per unsigned correction term.
REQ-004 Parameter CORR_SHIFT, default 3: left shift applied to correction terms (BITWIDTH-1).
REQ-005 Parameter N_BLS, default 2112: baseline words per frame.
REQ-006 Parameter MCNT_WIDTH, default 48: timestamp width.
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 sync_in  in  1  one-cycle frame sync pulse.
REQ-010 acc_vld  in  1  acc_in/corr_re/corr_im valid this cycle; no backpressure upstream.
REQ-011 acc_in  in  N_STOKES*2*ACC_COMP_WIDTH  unsigned accumulations; Stokes 0 at LSB, each {re,im}.
REQ-012 corr_re, corr_im  in  N_STOKES*CORR_WIDTH each  unsigned corrections, Stokes 0 at LSB.
REQ-013 mcnt_in  in  MCNT_WIDTH  timestamp, sampled on sync_in.
REQ-014 dout_rdy  in  1  downstream accepts dout when high with dout_vld.
REQ-015 dout  out  N_STOKES*2*ACC_COMP_WIDTH  corrected two's-complement words, same packing as acc_in.
REQ-016 dout_vld, dout_sof, dout_eof  out  1 each  valid, first word, last word of frame.
REQ-017 bl_idx  out  ceil(log2(N_BLS))  baseline index of dout word.
REQ-018 mcnt_out  out  MCNT_WIDTH  timestamp of frame currently on dout.
REQ-019 frame_err  out  1  one-cycle pulse on sync inside an incomplete frame.
REQ-020 drop_cnt  out  16  saturating count of words dropped on buffer full.

Function
REQ-021 Per component: result = acc - (corr << CORR_SHIFT), operands zero-extended, computed at ACC_COMP_WIDTH+2 bits, output ACC_COMP_WIDTH bits.
REQ-022 Pipeline: stage 1 registers difference and tags; stage 2 is a 2-entry output FIFO; dout_vld rises exactly 2 cycles after acc_vld when FIFO empty.
REQ-023 FSM states IDLE, ARMED, FRAME; IDLE->ARMED on sync_in; acc_vld ignored in IDLE.
REQ-024 ARMED->FRAME on acc_vld; that word gets bl_idx 0, sof=1, mcnt tag = held mcnt.
REQ-025 In FRAME each acc_vld increments bl_idx; word N_BLS-1 gets eof=1; FSM returns to ARMED; bl_idx wraps to 0.
REQ-026 sync_in in FRAME with bl_idx counter nonzero: frame_err pulses next cycle, FSM->ARMED, counter cleared; already-captured words still emitted, no eof.
REQ-027 sync_in and acc_vld same cycle in ARMED: word is sof of new frame, mcnt tag = mcnt_in of that cycle.
REQ-028 Held mcnt reloads on every sync_in; sof/eof/bl_idx/mcnt tags travel with data through FIFO.
REQ-029 FIFO full with dout_rdy low when stage 1 word arrives: word dropped, bl_idx still advances, drop_cnt +1, holds at 0xFFFF.
REQ-030 FIFO full with dout_rdy high same cycle: pop and push both occur, no drop.
REQ-031 dout and tags stable while dout_vld=1 and dout_rdy=0.

Reset
REQ-032 rst_n low: FSM IDLE, FIFO empty, pipeline valid cleared, dout_vld/sof/eof/frame_err 0, bl_idx 0, dout 0, mcnt_out 0, drop_cnt 0.
REQ-033 Reset mid-frame discards all in-flight words; after release a new sync_in is required before output.

Configuration
REQ-034 XENG_CORR_SAT_EN defined: each output component saturates to [-2^(ACC_COMP_WIDTH-1), 2^(ACC_COMP_WIDTH-1)-1]; undefined: low ACC_COMP_WIDTH bits kept (wrap), latency identical.

Verification
REQ-035 N_BLS=4, rdy=1, sync then 4 vld words acc_re=1000, corr_re=10 -> dout re=920, bl_idx 0..3, sof on word 0, eof on word 3, 2-cycle latency.
REQ-036 sync, 2 vld words, sync -> frame_err one pulse, 2 words output without eof, next vld gets sof with new mcnt.
REQ-037 rdy=0, 5 consecutive vld words -> 2 words held, drop_cnt=3, next frame's bl_idx still aligned.
REQ-038 ACC_COMP_WIDTH=18, acc_re=0, corr_re=4095 -> SAT_EN: re=-32760; without: re=(-32760) low 18 bits.
REQ-039 rst_n low mid-frame for 1 cycle -> all outputs 0; vld without sync after release produces no output.
